p_shfrot_ctrl: RTL and testbench

P_SHFROT_CTRL -- requirements
Module: p_shfrot_ctrl

---
 rtl/p_shfrot_pkg.sv | 23 ++
 rtl/p_shfrot.sv | 65 ++++++
 rtl/p_shfrot_ctrl.sv | 152 +++++++++++++++
 tb/tb_p_shfrot_ctrl.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/p_shfrot_pkg.sv
// Shared definitions for the packed shift/rotate controller:
// FSM state encoding, op bit positions, pack-width one-hot codes.
package p_shfrot_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam int OP_ROT_BIT   = 0;
  localparam int OP_RIGHT_BIT = 1;

  // pack width field is {w2,w4,w8,w16,w32}, so bit 0 selects 32-bit lanes
  localparam logic [4:0] PW_W32 = 5'b00001;
  localparam logic [4:0] PW_W16 = 5'b00010;
  localparam logic [4:0] PW_W8  = 5'b00100;
  localparam logic [4:0] PW_W4  = 5'b01000;
  localparam logic [4:0] PW_W2  = 5'b10000;

  function automatic logic pw_legal(input logic [4:0] pw);
    return (pw != 5'b00000) && ((pw & (pw - 5'd1)) == 5'b00000);
  endfunction

endpackage

// File: rtl/p_shfrot.sv
// Packed shift/rotate datapath (purely combinational).
// The 32-bit operand is split into lanes of the selected width; every lane
// is shifted or rotated independently by shamt modulo the lane width.
// An illegal (non one-hot) pack width yields err=1 and a zero result.
module p_shfrot
  import p_shfrot_pkg::*;
(
  input  logic [31:0] rs1,
  input  logic [4:0]  shamt,
  input  logic [4:0]  pw,
  input  logic        rotate,
  input  logic        right,
  output logic [31:0] result,
  output logic        err
);

  // per-bit source selection inside the lane of the selected width
  always_comb begin
    int w;
    int amt;
    int idx;
    int src;
    int base;
    logic hit;
    w      = 0;
    amt    = 0;
    idx    = 0;
    src    = 0;
    base   = 0;
    hit    = 1'b0;
    result = '0;
    err    = !pw_legal(pw);
    case (pw)
      PW_W32:  w = 32;
      PW_W16:  w = 16;
      PW_W8:   w = 8;
      PW_W4:   w = 4;
      PW_W2:   w = 2;
      default: w = 0;
    endcase
    if (!err) begin
      amt = int'(shamt) & (w - 1);
      for (int i = 0; i < 32; i++) begin
        idx  = i & (w - 1);
        base = i - idx;
        hit  = 1'b1;
        if (right) begin
          src = idx + amt;
          if (src >= w) begin
            if (rotate) src = src - w;
            else        hit = 1'b0;
          end
        end else begin
          src = idx - amt;
          if (src < 0) begin
            if (rotate) src = src + w;
            else        hit = 1'b0;
          end
        end
        result[i] = hit ? rs1[base + src] : 1'b0;
      end
    end
  end

endmodule

// File: rtl/p_shfrot_ctrl.sv
// Two-requester controller around the packed shift/rotate datapath.
// One operation in flight: accept in IDLE, compute in EXEC, hold in RESP.
// Build option: define P_SHFROT_CTRL_RR_EN for round-robin arbitration;
// otherwise requester 0 has fixed priority and no grant pointer exists.
//
// state | meaning
// IDLE  | waiting for a request, req_ready may be raised for the winner
// EXEC  | datapath runs on captured operands, result/err registered
// RESP  | rsp_valid to owner, result held until owner's rsp_ready
module p_shfrot_ctrl
  import p_shfrot_pkg::*;
#(
  parameter bit RSP_ZERO_IDLE = 1'b1
) (
  input  logic        g_clk,
  input  logic        g_reset,
  input  logic        flush,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [63:0] req_rs1,
  input  logic [9:0]  req_shamt,
  input  logic [9:0]  req_pw,
  input  logic [3:0]  req_op,
  output logic [1:0]  rsp_valid,
  input  logic [1:0]  rsp_ready,
  output logic [31:0] rsp_result,
  output logic        rsp_err
);

  logic [1:0]  state, state_nxt;
  logic        sel;
  logic        accept;
  logic [1:0]  op_sel;
  logic [31:0] op_rs1;
  logic [4:0]  op_shamt;
  logic [4:0]  op_pw;
  logic        op_rot;
  logic        op_right;
  logic        op_id;
  logic [31:0] res_q;
  logic        err_q;
  logic [31:0] dp_result;
  logic        dp_err;

`ifdef P_SHFROT_CTRL_RR_EN
  logic last_id;

  // round-robin winner: under contention the requester not granted last wins
  always_comb begin
    sel = 1'b0;
    if (req_valid[0]) sel = req_valid[1] ? ~last_id : 1'b0;
    else              sel = 1'b1;
  end

  // grant pointer moves only on an actual accept; reset favours requester 0
  always_ff @(posedge g_clk or posedge g_reset) begin
    if (g_reset)     last_id <= 1'b1;
    else if (accept) last_id <= sel;
  end
`else
  // fixed priority winner: requester 0 whenever it is requesting
  always_comb begin
    sel = ~req_valid[0];
  end
`endif

  // ready only to the winner, only in IDLE, never while flushing or in reset
  always_comb begin
    req_ready = 2'b00;
    if (state == ST_IDLE && !flush && !g_reset && req_valid != 2'b00)
      req_ready = 2'b01 << sel;
  end

  assign accept = |(req_valid & req_ready);
  assign op_sel = sel ? req_op[3:2] : req_op[1:0];

  // next-state logic; flush overrides every other transition
  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: if (accept) state_nxt = ST_EXEC;
        ST_EXEC: state_nxt = ST_RESP;
        ST_RESP: if (rsp_ready[op_id]) state_nxt = ST_IDLE;
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  // state register
  always_ff @(posedge g_clk or posedge g_reset) begin
    if (g_reset) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  // operand capture; cleared on reset and flush so no operand data lingers
  always_ff @(posedge g_clk or posedge g_reset) begin
    if (g_reset) begin
      op_rs1   <= '0;
      op_shamt <= '0;
      op_pw    <= '0;
      op_rot   <= 1'b0;
      op_right <= 1'b0;
      op_id    <= 1'b0;
    end else if (flush) begin
      op_rs1   <= '0;
      op_shamt <= '0;
      op_pw    <= '0;
      op_rot   <= 1'b0;
      op_right <= 1'b0;
      op_id    <= 1'b0;
    end else if (accept) begin
      op_rs1   <= sel ? req_rs1[63:32]  : req_rs1[31:0];
      op_shamt <= sel ? req_shamt[9:5]  : req_shamt[4:0];
      op_pw    <= sel ? req_pw[9:5]     : req_pw[4:0];
      op_rot   <= op_sel[OP_ROT_BIT];
      op_right <= op_sel[OP_RIGHT_BIT];
      op_id    <= sel;
    end
  end

  p_shfrot u_p_shfrot (
    .rs1    (op_rs1),
    .shamt  (op_shamt),
    .pw     (op_pw),
    .rotate (op_rot),
    .right  (op_right),
    .result (dp_result),
    .err    (dp_err)
  );

  // result/err registered in EXEC and held through RESP
  always_ff @(posedge g_clk or posedge g_reset) begin
    if (g_reset) begin
      res_q <= '0;
      err_q <= 1'b0;
    end else if (flush) begin
      res_q <= '0;
      err_q <= 1'b0;
    end else if (state == ST_EXEC) begin
      res_q <= dp_result;
      err_q <= dp_err;
    end
  end

  assign rsp_valid  = (state == ST_RESP) ? (2'b01 << op_id) : 2'b00;
  assign rsp_result = (RSP_ZERO_IDLE && rsp_valid == 2'b00) ? 32'h0 : res_q;
  assign rsp_err    = (RSP_ZERO_IDLE && rsp_valid == 2'b00) ? 1'b0  : err_q;

endmodule

// File: tb/tb_p_shfrot_ctrl.sv
// Directed bench for p_shfrot_ctrl with hand-computed expected values.
module tb_p_shfrot_ctrl;

  logic        g_clk = 1'b0;
  logic        g_reset = 1'b1;
  logic        flush = 1'b0;
  logic [1:0]  req_valid = 2'b00;
  logic [1:0]  req_ready;
  logic [63:0] req_rs1 = '0;
  logic [9:0]  req_shamt = '0;
  logic [9:0]  req_pw = '0;
  logic [3:0]  req_op = '0;
  logic [1:0]  rsp_valid;
  logic [1:0]  rsp_ready = 2'b00;
  logic [31:0] rsp_result;
  logic        rsp_err;

  int n_chk = 0;
  int n_err = 0;
  int owners[4];
  int got_n;

  p_shfrot_ctrl dut (
    .g_clk      (g_clk),
    .g_reset    (g_reset),
    .flush      (flush),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_rs1    (req_rs1),
    .req_shamt  (req_shamt),
    .req_pw     (req_pw),
    .req_op     (req_op),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_err    (rsp_err)
  );

  always #5 g_clk = ~g_clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge g_clk);
    #1;
  endtask

  task automatic load(input int id, input logic [31:0] rs1, input logic [4:0] sh,
                      input logic [4:0] pw, input logic [1:0] op);
    req_rs1[32*id +: 32] = rs1;
    req_shamt[5*id +: 5] = sh;
    req_pw[5*id +: 5]    = pw;
    req_op[2*id +: 2]    = op;
  endtask

  // accept cycle, EXEC cycle, RESP cycle (accept+2), then release
  task automatic run_op(input string tag, input int id, input logic [31:0] rs1,
                        input logic [4:0] sh, input logic [4:0] pw, input logic [1:0] op,
                        input logic [31:0] exp_res, input logic exp_err);
    load(id, rs1, sh, pw, op);
    req_valid = 2'b01 << id;
    #1;
    chk({tag, "_ready"}, req_ready, 2'b01 << id);
    tick();
    req_valid = 2'b00;
    #1;
    chk({tag, "_exec_vld"}, rsp_valid, 2'b00);
    tick();
    chk({tag, "_vld"}, rsp_valid, 2'b01 << id);
    chk({tag, "_res"}, rsp_result, exp_res);
    chk({tag, "_err"}, rsp_err, exp_err);
    rsp_ready = 2'b01 << id;
    tick();
    rsp_ready = 2'b00;
    chk({tag, "_done"}, rsp_valid, 2'b00);
  endtask

  initial begin
    // reset state, with a request pending to prove req_ready stays low
    req_valid = 2'b01;
    tick();
    chk("rst_ready", req_ready, 2'b00);
    chk("rst_vld", rsp_valid, 2'b00);
    chk("rst_res", rsp_result, 32'h0);
    chk("rst_err", rsp_err, 1'b0);
    req_valid = 2'b00;
    g_reset = 1'b0;
    tick();

    run_op("rotl_w32", 0, 32'h8000_0001, 5'd1, 5'b00001, 2'b01, 32'h0000_0003, 1'b0);
    run_op("shr_w8",   1, 32'hF0F0_F0F0, 5'd4, 5'b00100, 2'b10, 32'h0F0F_0F0F, 1'b0);
    run_op("rotr_w2",  0, 32'h0000_00F1, 5'd1, 5'b10000, 2'b11, 32'h0000_00F2, 1'b0);
    run_op("rotl_w4",  1, 32'h1234_5678, 5'd3, 5'b01000, 2'b01, 32'h8192_A3B4, 1'b0);
    run_op("pw_two",   0, 32'hFFFF_FFFF, 5'd0, 5'b00011, 2'b00, 32'h0000_0000, 1'b1);
    run_op("pw_zero",  1, 32'hDEAD_BEEF, 5'd2, 5'b00000, 2'b01, 32'h0000_0000, 1'b1);

    // stall in RESP; non-owner rsp_ready and a pending request are ignored
    load(0, 32'h1234_ABCD, 5'd4, 5'b00010, 2'b00);
    req_valid = 2'b01;
    tick();
    req_valid = 2'b00;
    tick();
    load(1, 32'h0000_0001, 5'd0, 5'b00001, 2'b00);
    req_valid = 2'b10;
    rsp_ready = 2'b10;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("stall_vld", rsp_valid, 2'b01);
      chk("stall_res", rsp_result, 32'h2340_BCD0);
      chk("stall_ready", req_ready, 2'b00);
      tick();
    end
    rsp_ready = 2'b01;
    tick();
    chk("stall_release", rsp_valid, 2'b00);
    chk("stall_next_ready", req_ready, 2'b10);
    req_valid = 2'b00;
    rsp_ready = 2'b00;
    tick();

    // flush in IDLE blocks req_ready
    req_valid = 2'b01;
    flush = 1'b1;
    #1;
    chk("flush_idle_ready", req_ready, 2'b00);
    tick();
    req_valid = 2'b00;
    flush = 1'b0;
    chk("flush_idle_vld", rsp_valid, 2'b00);

    // flush in RESP wins over rsp_ready, then a new request goes through
    load(0, 32'h0000_00FF, 5'd8, 5'b00001, 2'b00);
    req_valid = 2'b01;
    tick();
    req_valid = 2'b00;
    tick();
    chk("flush_resp_pre", rsp_valid, 2'b01);
    flush = 1'b1;
    rsp_ready = 2'b01;
    tick();
    flush = 1'b0;
    rsp_ready = 2'b00;
    chk("flush_resp_vld", rsp_valid, 2'b00);
    run_op("after_flush", 1, 32'h0000_0001, 5'd31, 5'b00001, 2'b00, 32'h8000_0000, 1'b0);

    // reset while in EXEC drops the operation
    load(1, 32'hAAAA_5555, 5'd1, 5'b00001, 2'b01);
    req_valid = 2'b10;
    tick();
    req_valid = 2'b11;
    g_reset = 1'b1;
    #1;
    chk("rst_exec_ready", req_ready, 2'b00);
    chk("rst_exec_vld", rsp_valid, 2'b00);
    chk("rst_exec_res", rsp_result, 32'h0);
    chk("rst_exec_err", rsp_err, 1'b0);
    req_valid = 2'b00;
    tick();
    g_reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_exec_noresp", rsp_valid, 2'b00);
    end

    // contention from a fresh reset, both valid and rsp_ready held high
    g_reset = 1'b1;
    tick();
    g_reset = 1'b0;
    load(0, 32'h0000_0001, 5'd1, 5'b00001, 2'b00);
    load(1, 32'h0000_0001, 5'd2, 5'b00001, 2'b00);
    req_valid = 2'b11;
    rsp_ready = 2'b11;
    got_n = 0;
    for (int c = 0; c < 40 && got_n < 4; c++) begin
      tick();
      if (rsp_valid != 2'b00) begin
        owners[got_n] = (rsp_valid == 2'b10) ? 1 : 0;
        got_n++;
      end
    end
    req_valid = 2'b00;
    rsp_ready = 2'b00;
    chk("arb_count", got_n, 4);
    for (int k = 0; k < 4; k++) begin
`ifdef P_SHFROT_CTRL_RR_EN
      chk("arb_owner", owners[k], k % 2);
`else
      chk("arb_owner", owners[k], 0);
`endif
    end
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
